wht_radix2_sequencer: RTL and testbench
=======================================

# wht_radix2_sequencer

In-place sequencer that time-shares one external combinational radix-2 butterfly (sum/difference unit, 8-bit signed wrap-around) across all stages of an N-point unity-twiddle radix-2 transform (Sylvester Walsh–Hadamard flow graph). It buffers a frame of N samples from an input stream and schedules LOG2N stages of N/2 butterflies, one butterfly per cycle, through the shared unit. It then streams the N results out in natural order. It sits between the sample source and downstream bin processing, with the butterfly instance wired beside it.

## Interface
- LOG2N, 3: log2 of frame length N; legal 1..6.
- W, 8: sample width, two's complement.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- s_data  in  W  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block accepts a sample this cycle.
- bf_a  out  W  butterfly operand 1 (buffer word at lo address).
- bf_b  out  W  butterfly operand 2 (buffer word at hi address).
- bf_sum  in  W  butterfly result a+b, same cycle, combinational.
- bf_diff  in  W  butterfly result a−b, same cycle, combinational.
- m_data  out  W  output bin.
- m_valid  out  1  output bin valid.
- m_ready  in  1  downstream accepts bin.
- m_last  out  1  marks bin N−1.
- busy  out  1  high in RUN or DRAIN.

## Operation
- Storage: N×W register buffer; addr counter (LOG2N bits), stage counter s (0..LOG2N−1), butterfly counter b (0..N/2−1).
- FSM states LOAD, RUN, DRAIN. Reset → LOAD, all counters 0, buffer contents don't-care.
- LOAD: s_ready=1. On s_valid&&s_ready, write s_data to buf[addr] and increment addr. Sample N−1 accepted → RUN, addr=0.
- RUN: s_ready=0, busy=1. span=N>>(s+1); lo=((b>>(LOG2N−1−s))<<(LOG2N−s)) | (b&(span−1)); hi=lo+span. bf_a=buf[lo], bf_b=buf[hi]. At the clock edge, buf[lo]←bf_sum and buf[hi]←bf_diff. b increments. When b=N/2−1, b←0 and s increments. Last butterfly (s=LOG2N−1, b=N/2−1) → DRAIN.
- DRAIN: m_valid=1, m_data=buf[addr], m_last=(addr==N−1). addr increments on m_valid&&m_ready. Bin N−1 handshaked → LOAD, addr=0.
- Arithmetic: no saturation and no scaling. Results are whatever the butterfly returns (mod 2^W). The block never alters bf_sum/bf_diff.
- bf_a/bf_b are driven from the addressed buffer words in every state. They are don't-care outside RUN; the block ignores bf_sum/bf_diff outside RUN.
- Output order: natural Hadamard order; bin k = Σ x[n]·(−1)^popcount(k&n) mod 2^W.
- Reset mid-operation: reset asserted in any state returns the block to LOAD within the same edge. It discards the partial frame and drops m_valid. No output is produced for the aborted frame.

## Timing
- Reset values (cycle after rst_n low edge): s_ready=1, m_valid=0, m_last=0, busy=0, m_data don't-care.
- Load: N accepting cycles minimum; s_valid gaps stall addr with no penalty.
- RUN: exactly LOG2N·N/2 cycles, no stalls. It starts the cycle after the last sample is accepted.
- First m_valid: cycle after last butterfly. Minimum frame period N + LOG2N·N/2 + N cycles (N=8: 28).
- s_ready=0 throughout RUN and DRAIN. There is no overlap of frames.
- Output handshake: m_data/m_last hold stable while m_valid && !m_ready.
- Return to LOAD: s_ready=1 the cycle after the last bin is handshaked. A sample can then be accepted that cycle.

## Test plan
- N=8, impulse [1,0,0,0,0,0,0,0] → bins all 1, m_last only on 8th, busy high 12+8 cycles.
- N=8, input 1..8 → [36,−4,−8,0,−16,0,0,0].
- N=8, constant 20 → bin0 = 160 wraps to −96, bins1..7 = 0; confirms no saturation.
- Random s_valid gaps on load and random m_ready deassertion on drain → same bins as gap-free run; m_data/m_last stable while stalled; no sample accepted during RUN/DRAIN.
- rst_n low during RUN (stage 1) and again during DRAIN (3rd bin) → next cycle s_ready=1, m_valid=0, busy=0; following impulse frame yields all-ones.
- Back-to-back frames, m_ready tied 1, s_valid tied 1 → frame period exactly 28 cycles; results of each frame independent of the previous one.

Source files
------------

// File: rtl/wht_radix2_sequencer.sv
// In-place Walsh-Hadamard frame sequencer: buffers N samples, drives one shared
// external sum/difference butterfly through LOG2N stages, then streams bins out.
module wht_radix2_sequencer #(
  parameter int LOG2N = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] bf_a,
  output logic [W-1:0] bf_b,
  input  logic [W-1:0] bf_sum,
  input  logic [W-1:0] bf_diff,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int BW = (LOG2N > 1) ? LOG2N - 1 : 1;

  localparam logic [LOG2N-1:0] ADDR_LAST = '1;
  localparam logic [LOG2N-1:0] HALF      = LOG2N'(N / 2);
  localparam logic [BW-1:0]    B_LAST    = BW'(N / 2 - 1);
  localparam logic [SW-1:0]    S_LAST    = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_buf [N];
  logic [LOG2N-1:0] r_addr;
  logic [SW-1:0]    r_s;
  logic [BW-1:0]    r_b;

  logic [LOG2N-1:0] w_bx;
  logic [LOG2N-1:0] w_span;
  logic [SW:0]      w_shift;
  logic [LOG2N-1:0] w_lo;
  logic [LOG2N-1:0] w_hi;
  logic             w_load_acc;
  logic             w_out_acc;
  logic             w_last;

  // Butterfly addressing: b's upper bits select the group (stride 2*span),
  // its low bits the offset inside the group; the shift field is one bit wider
  // than r_s so that (shift + 1) cannot overflow for small LOG2N.
  always_comb begin
    w_bx    = LOG2N'(r_b);
    w_span  = HALF >> r_s;
    w_shift = (SW+1)'(LOG2N - 1) - {1'b0, r_s};
    w_lo    = ((w_bx >> w_shift) << (w_shift + 1'b1)) | (w_bx & (w_span - 1'b1));
    w_hi    = w_lo + w_span;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b0;
    w_last      = 1'b0;
    w_load_acc  = 1'b0;
    w_out_acc   = 1'b0;
    case (r_state)
      LOAD: begin
        s_ready    = 1'b1;
        w_load_acc = s_valid;
        if (s_valid && (r_addr == ADDR_LAST)) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if ((r_s == S_LAST) && (r_b == B_LAST)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        m_valid   = 1'b1;
        w_last    = (r_addr == ADDR_LAST);
        w_out_acc = m_ready;
        if (m_ready && w_last) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  assign m_last = w_last;
  assign m_data = r_buf[r_addr];
  assign bf_a   = r_buf[w_lo];
  assign bf_b   = r_buf[w_hi];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // addr wraps to 0 naturally after word N-1 in both LOAD and DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_s    <= '0;
      r_b    <= '0;
    end else begin
      if (w_load_acc || w_out_acc) r_addr <= r_addr + 1'b1;
      if (r_state == RUN) begin
        if (r_b == B_LAST) begin
          r_b <= '0;
          r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
        end else begin
          r_b <= r_b + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_buf[r_addr] <= s_data;
    end else if (r_state == RUN) begin
      r_buf[w_lo] <= bf_sum;
      r_buf[w_hi] <= bf_diff;
    end
  end

endmodule

// File: tb/tb_wht_radix2_sequencer.sv
// Directed bench for wht_radix2_sequencer (N=8, W=8) with a behavioural
// wrap-around butterfly wired beside the DUT.
module tb_wht_radix2_sequencer;

  localparam int LOG2N = 3;
  localparam int W     = 8;
  localparam int N     = 8;

  typedef int vec_t [N];

  logic         clk;
  logic         rst_n;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] bf_a;
  logic [W-1:0] bf_b;
  logic [W-1:0] bf_sum;
  logic [W-1:0] bf_diff;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;

  int n_cmp;
  int n_fail;

  wht_radix2_sequencer #(.LOG2N(LOG2N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .bf_a    (bf_a),
    .bf_b    (bf_b),
    .bf_sum  (bf_sum),
    .bf_diff (bf_diff),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy)
  );

  assign bf_sum  = bf_a + bf_b;
  assign bf_diff = bf_a - bf_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_w(input int v);
    logic [31:0] t;
    t = v;
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"},  m_last,  0);
    chk({tag, "_busy"},    busy,    0);
  endtask

  task automatic load_frame(input vec_t x, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          s_data  = 8'h5A;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = to_w(x[i]);
      chk("load_s_ready", s_ready, 1);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_phase(input bit junk);
    int cnt;
    cnt = 0;
    if (junk) begin
      s_valid = 1'b1;
      s_data  = 8'h77;
    end
    while (busy && !m_valid && cnt < 40) begin
      if (junk) chk("run_s_ready", s_ready, 0);
      tick();
      cnt++;
    end
    chk("run_len", cnt, 12);
  endtask

  task automatic drain_phase(input vec_t e, input bit stalls);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < N && guard < 200) begin
      guard++;
      chk("drain_m_valid", m_valid, 1);
      chk("drain_busy", busy, 1);
      chk("drain_s_ready", s_ready, 0);
      chk("drain_m_data", m_data, to_w(e[k]));
      chk("drain_m_last", m_last, (k == N - 1) ? 1 : 0);
      if (stalls && $urandom_range(0, 2) == 0) begin
        m_ready = 1'b0;
        tick();
      end else begin
        m_ready = 1'b1;
        tick();
        k++;
      end
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk("drain_count", k, N);
    chk_idle("post_drain");
  endtask

  task automatic frame(input vec_t x, input vec_t e, input bit gaps, input bit stalls);
    load_frame(x, gaps);
    run_phase(gaps);
    drain_phase(e, stalls);
  endtask

  vec_t v_imp   = '{1, 0, 0, 0, 0, 0, 0, 0};
  vec_t e_imp   = '{1, 1, 1, 1, 1, 1, 1, 1};
  vec_t v_seq   = '{1, 2, 3, 4, 5, 6, 7, 8};
  vec_t e_seq   = '{36, -4, -8, 0, -16, 0, 0, 0};
  vec_t v_c20   = '{20, 20, 20, 20, 20, 20, 20, 20};
  vec_t e_c20   = '{-96, 0, 0, 0, 0, 0, 0, 0};
  vec_t v_edge  = '{-128, 127, 0, 0, 0, 0, 0, 0};
  vec_t e_edge  = '{-1, 1, -1, 1, -1, 1, -1, 1};

  initial begin
    vec_t frames [3];
    vec_t exps   [3];
    int   t_start [3];
    int   cyc, fi, si, bo;
    bit   acc;

    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    tick();
    chk_idle("reset");
    rst_n = 1'b1;

    frame(v_imp,  e_imp,  1'b0, 1'b0);
    frame(v_seq,  e_seq,  1'b0, 1'b0);
    frame(v_c20,  e_c20,  1'b0, 1'b0);
    frame(v_edge, e_edge, 1'b0, 1'b0);
    frame(v_seq,  e_seq,  1'b1, 1'b1);
    frame(v_edge, e_edge, 1'b1, 1'b1);

    // Abort during RUN, stage 1 (fifth butterfly cycle).
    load_frame(v_seq, 1'b0);
    repeat (5) tick();
    chk("abort_run_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    chk_idle("abort_run");
    rst_n = 1'b1;
    frame(v_imp, e_imp, 1'b0, 1'b0);

    // Abort during DRAIN while the third bin is presented.
    load_frame(v_c20, 1'b0);
    run_phase(1'b0);
    m_ready = 1'b1;
    tick();
    tick();
    chk("abort_drain_m_valid_before", m_valid, 1);
    rst_n = 1'b0;
    tick();
    chk_idle("abort_drain");
    rst_n   = 1'b1;
    m_ready = 1'b0;
    frame(v_imp, e_imp, 1'b0, 1'b0);

    // Back-to-back frames with both handshakes tied high.
    frames[0] = v_seq;  exps[0] = e_seq;
    frames[1] = v_imp;  exps[1] = e_imp;
    frames[2] = v_c20;  exps[2] = e_c20;
    t_start = '{-1, -1, -1};
    cyc = 0; fi = 0; si = 0; bo = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    while (bo < 3 * N && cyc < 200) begin
      s_data = (fi < 3) ? to_w(frames[fi][si]) : '0;
      if (s_ready && si == 0 && fi < 3) t_start[fi] = cyc;
      if (m_valid) begin
        chk("b2b_m_data", m_data, to_w(exps[bo / N][bo % N]));
        chk("b2b_m_last", m_last, (bo % N == N - 1) ? 1 : 0);
        bo++;
      end
      acc = s_ready;
      tick();
      cyc++;
      if (acc) begin
        si++;
        if (si == N) begin
          si = 0;
          fi++;
        end
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("b2b_bins", bo, 3 * N);
    chk("b2b_period_0_1", t_start[1] - t_start[0], 28);
    chk("b2b_period_1_2", t_start[2] - t_start[1], 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
